ex_mem_pipe: RTL and testbench
==============================

// Module: ex_mem_pipe
// PURPOSE
//  EX/MEM pipeline boundary. Sits between execute and the memory stage and holds
//  one ALU result, store data and memory/writeback controls per instruction.
//  Uses valid/ready handshakes with a 2-entry skid, so a stalled memory stage
//  back-pressures execute without losing an instruction. Supports flush and
//  counts stall cycles.
// PARAMETERS
//  DATA_W  16  width of ALU result and store data
//  RADR_W  3   width of destination register address
//  CNT_W   16  width of the saturating stall counter
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  rst          in   1       async active-low reset; asserts immediately, releases synchronously to clk
//  flush        in   1       sync; drops all held entries
//  clr_stat     in   1       sync; clears stall_cnt
//  in_valid     in   1       execute presents an instruction
//  in_ready     out  1       stage can accept (registered)
//  AluResIn     in   DATA_W  ALU result / memory address
//  RtIn         in   DATA_W  store data
//  RegWriteIn   in   1       register writeback enable
//  DMemWriteIn  in   1       data memory write
//  DMemEnIn     in   1       data memory enable
//  MemToRegIn   in   1       select memory data for writeback
//  DMemDumpIn   in   1       halt / memory dump
//  RdAddrIn     in   RADR_W  destination register
//  out_valid    out  1       memory stage has a valid instruction
//  out_ready    in   1       memory stage consumes it this cycle
//  AluResOut, RtOut, RegWriteOut, DMemWriteOut, DMemEnOut, MemToRegOut,
//  DMemDumpOut, RdAddrOut   out  (same widths as inputs)   head-entry payload
//  occupancy    out  2       held entries: 0, 1 or 2
//  stall_cnt    out  CNT_W   cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Handshake and storage
//  - A transfer happens on an edge where valid=1 and ready=1.
//  - in_ready equals !skid_valid and is registered.
//  - Storage: main entry (drives outputs) plus skid entry.
//  - States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
//  Transitions (no flush)
//  - EMPTY: in_valid -> ONE, main<=in.
//  - ONE: in_valid&out_ready -> ONE, main<=in.
//  - ONE: !in_valid&out_ready -> EMPTY.
//  - ONE: in_valid&!out_ready -> FULL, skid<=in.
//  - ONE: no in_valid and no out_ready -> ONE, hold.
//  - FULL: out_ready -> ONE, main<=skid. in_ready=0, so inputs are ignored.
//  - FULL: !out_ready -> FULL, hold.
//  Latency and throughput
//  - Input to out_valid latency is 1 cycle. Sustained throughput is 1 per cycle.
//  - Order is preserved; no entry is duplicated or dropped except by flush.
//  Flush
//  - Highest priority. Next state is EMPTY and both valid bits clear.
//  - An input offered in the flush cycle is discarded, even if in_ready=1.
//  - An output offered in the flush cycle still counts as consumed if out_ready=1.
//  Bubble gating
//  - While out_valid=0, RegWriteOut, DMemWriteOut, DMemEnOut and DMemDumpOut are
//    forced to 0.
//  - The data outputs hold their last value; only the control outputs are gated.
//  Stall counter
//  - Increments each cycle out_valid&!out_ready and saturates at all-ones.
//  - clr_stat clears it. If clr_stat and a stall occur in the same cycle, the
//    result is 0.
//  Reset (rst=0)
//  - State EMPTY; out_valid=0; in_ready=1; occupancy=0; stall_cnt=0.
//  - All payload registers are 0.
//  - Reset mid-transfer discards all entries.
// TESTING
//  1 Stream 0x0001..0x0005 with out_ready=1 -> each appears 1 cycle later, in order;
//    occupancy stays at 1 or less.
//  2 Accept A=0x1234, hold out_ready=0, offer B=0xBEEF and C=0xCAFE.
//    -> occupancy=2, in_ready=0, C is not taken.
//    -> after release, out shows A then B, then C is accepted.
//  3 Hold out_ready=0 for 7 cycles with an entry held -> stall_cnt=7.
//    Pulse clr_stat -> stall_cnt=0. With CNT_W forced to 4, 20 stalls -> 0xF.
//  4 FULL state, then flush with in_valid=1 and data 0x5555.
//    -> next cycle out_valid=0, occupancy=0, RegWriteOut=0, DMemEnOut=0, 0x5555 never emitted.
//  5 Assert rst low mid-stream, asynchronously to clk.
//    -> out_valid=0 and occupancy=0 without waiting for a clock edge.
//    -> after release, the first accepted entry emerges normally.
//  6 With DMemDumpIn=1 and RdAddrIn=3'b101, entry passes through unchanged.
//    -> DMemDumpOut=0 whenever out_valid=0.

Source files
------------

// File: rtl/ex_mem_pipe_if.sv
// EX/MEM boundary bundle: execute-side inputs, memory-side outputs, flush/clear
// controls and status. The pipe register takes the slave view.
interface ex_mem_pipe_if #(
    parameter int DATA_W = 16,
    parameter int RADR_W = 3,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              clr_stat;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] AluResIn;
    logic [DATA_W-1:0] RtIn;
    logic              RegWriteIn;
    logic              DMemWriteIn;
    logic              DMemEnIn;
    logic              MemToRegIn;
    logic              DMemDumpIn;
    logic [RADR_W-1:0] RdAddrIn;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] AluResOut;
    logic [DATA_W-1:0] RtOut;
    logic              RegWriteOut;
    logic              DMemWriteOut;
    logic              DMemEnOut;
    logic              MemToRegOut;
    logic              DMemDumpOut;
    logic [RADR_W-1:0] RdAddrOut;

    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, clr_stat,
        output in_valid, AluResIn, RtIn, RegWriteIn, DMemWriteIn, DMemEnIn,
               MemToRegIn, DMemDumpIn, RdAddrIn,
        input  in_ready,
        input  out_valid, AluResOut, RtOut, RegWriteOut, DMemWriteOut, DMemEnOut,
               MemToRegOut, DMemDumpOut, RdAddrOut,
        output out_ready,
        input  occupancy, stall_cnt
    );

    modport slave (
        input  flush, clr_stat,
        input  in_valid, AluResIn, RtIn, RegWriteIn, DMemWriteIn, DMemEnIn,
               MemToRegIn, DMemDumpIn, RdAddrIn,
        output in_ready,
        output out_valid, AluResOut, RtOut, RegWriteOut, DMemWriteOut, DMemEnOut,
               MemToRegOut, DMemDumpOut, RdAddrOut,
        input  out_ready,
        output occupancy, stall_cnt
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a 2-entry skid (main + skid), flush and a
// saturating stall counter. Control outputs are forced low during bubbles.
module ex_mem_pipe #(
    parameter int DATA_W = 16,
    parameter int RADR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_pipe_if.slave bus
);
    // Payload layout, MSB first: AluRes, Rt, {RegWrite, DMemWrite, DMemEn, MemToReg, DMemDump}, RdAddr
    localparam int         PW        = 2 * DATA_W + 5 + RADR_W;
    localparam logic [4:0] GATE_MASK = 5'b11101;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [PW-1:0]    in_payload;
    logic             accept;
    logic             out_valid;
    logic             stall;
    logic [4:0]       ctrl_raw;
    logic [4:0]       ctrl_out;

    assign in_payload = {bus.AluResIn, bus.RtIn, bus.RegWriteIn, bus.DMemWriteIn,
                         bus.DMemEnIn, bus.MemToRegIn, bus.DMemDumpIn, bus.RdAddrIn};
    assign accept     = bus.in_valid & in_ready_q;
    assign out_valid  = (state_q != S_EMPTY);
    assign stall      = out_valid & ~bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    main_d  = in_payload;
                end
            end
            S_ONE: begin
                if (accept && bus.out_ready) begin
                    main_d = in_payload;
                end else if (accept) begin
                    state_d = S_FULL;
                    skid_d  = in_payload;
                end else if (bus.out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (bus.out_ready) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush wins over everything; keep main untouched so a discarded
        // input never shows up on the data outputs.
        if (bus.flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    assign in_ready_d = (state_d != S_FULL);

    always_comb begin
        stall_d = stall_q;
        if (bus.clr_stat) begin
            stall_d = '0;
        end else if (stall && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign ctrl_raw = main_q[RADR_W +: 5];

    // MemToReg is left ungated; the other four control bits are side-effecting.
    for (genvar gi = 0; gi < 5; gi++) begin : g_gate
        if (GATE_MASK[gi]) begin : g_on
            assign ctrl_out[gi] = ctrl_raw[gi] & out_valid;
        end else begin : g_off
            assign ctrl_out[gi] = ctrl_raw[gi];
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid;
    assign bus.AluResOut    = main_q[PW-1 -: DATA_W];
    assign bus.RtOut        = main_q[PW-1-DATA_W -: DATA_W];
    assign bus.RegWriteOut  = ctrl_out[4];
    assign bus.DMemWriteOut = ctrl_out[3];
    assign bus.DMemEnOut    = ctrl_out[2];
    assign bus.MemToRegOut  = ctrl_out[1];
    assign bus.DMemDumpOut  = ctrl_out[0];
    assign bus.RdAddrOut    = main_q[RADR_W-1:0];
    assign bus.occupancy    = (state_q == S_FULL) ? 2'd2 :
                              (state_q == S_ONE)  ? 2'd1 : 2'd0;
    assign bus.stall_cnt    = stall_q;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// Randomized and directed bench for ex_mem_pipe against a queue-based model of
// the held instructions.
module tb_ex_mem_pipe;
    localparam int DATA_W = 16;
    localparam int RADR_W = 3;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_mem_pipe_if #(.DATA_W(DATA_W), .RADR_W(RADR_W), .CNT_W(CNT_W)) bus ();
    ex_mem_pipe_if #(.DATA_W(DATA_W), .RADR_W(RADR_W), .CNT_W(4))     bus4 ();

    ex_mem_pipe #(.DATA_W(DATA_W), .RADR_W(RADR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    ex_mem_pipe #(.DATA_W(DATA_W), .RADR_W(RADR_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] rt;
        logic        rw;
        logic        dw;
        logic        de;
        logic        m2r;
        logic        dump;
        logic [2:0]  rd;
    } entry_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the ordered list of instructions held by the stage.
    entry_t      q[$];
    entry_t      last_main = '0;
    int unsigned m_stall   = 0;

    function automatic entry_t dut_out();
        entry_t e;
        e.alu  = bus.AluResOut;
        e.rt   = bus.RtOut;
        e.rw   = bus.RegWriteOut;
        e.dw   = bus.DMemWriteOut;
        e.de   = bus.DMemEnOut;
        e.m2r  = bus.MemToRegOut;
        e.dump = bus.DMemDumpOut;
        e.rd   = bus.RdAddrOut;
        return e;
    endfunction

    function automatic entry_t exp_out();
        entry_t e;
        e = (q.size() > 0) ? q[0] : last_main;
        if (q.size() == 0) begin
            e.rw = 1'b0; e.dw = 1'b0; e.de = 1'b0; e.dump = 1'b0;
        end
        return e;
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        e.alu  = 16'($urandom);
        e.rt   = 16'($urandom);
        e.rw   = 1'($urandom);
        e.dw   = 1'($urandom);
        e.de   = 1'($urandom);
        e.m2r  = 1'($urandom);
        e.dump = 1'($urandom);
        e.rd   = 3'($urandom);
        return e;
    endfunction

    task automatic drive(input bit v, input entry_t e);
        bus.in_valid    = v;
        bus.AluResIn    = e.alu;
        bus.RtIn        = e.rt;
        bus.RegWriteIn  = e.rw;
        bus.DMemWriteIn = e.dw;
        bus.DMemEnIn    = e.de;
        bus.MemToRegIn  = e.m2r;
        bus.DMemDumpIn  = e.dump;
        bus.RdAddrIn    = e.rd;
    endtask

    // Advance one clock; the model applies the rules to the inputs present at the edge.
    task automatic tick();
        entry_t inp;
        bit     v, ordy, fl, clr, rdy_before, rst_now;
        inp.alu = bus.AluResIn; inp.rt = bus.RtIn; inp.rw = bus.RegWriteIn;
        inp.dw = bus.DMemWriteIn; inp.de = bus.DMemEnIn; inp.m2r = bus.MemToRegIn;
        inp.dump = bus.DMemDumpIn; inp.rd = bus.RdAddrIn;
        v = bus.in_valid; ordy = bus.out_ready; fl = bus.flush; clr = bus.clr_stat;
        rdy_before = (q.size() < 2);
        rst_now = rst;
        @(posedge clk);
        if (!rst_now) begin
            q.delete(); last_main = '0; m_stall = 0;
        end else begin
            if (clr) m_stall = 0;
            else if (q.size() > 0 && !ordy && m_stall < 32'hFFFF) m_stall++;
            if (fl) begin
                q.delete();
            end else begin
                if (q.size() > 0 && ordy) void'(q.pop_front());
                if (v && rdy_before) q.push_back(inp);
            end
            if (q.size() > 0) last_main = q[0];
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.flush = 1'b0; bus.clr_stat = 1'b0;
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %h expected 0", bus.stall_cnt); end
        n_cmp++; if (dut_out() !== entry_t'(0)) begin n_bad++; $display("FAIL reset_payload: got %h expected 0", dut_out()); end
        rst = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_stream();
        entry_t e;
        drain();
        for (int i = 1; i <= 5; i++) begin
            e = rand_entry(); e.alu = 16'(i);
            drive(1'b1, e);
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.AluResOut !== 16'(i)) begin
                n_bad++; $display("FAIL stream_data: got v=%b %h expected v=1 %h", bus.out_valid, bus.AluResOut, 16'(i)); end
            n_cmp++; if (bus.occupancy > 2'd1) begin n_bad++; $display("FAIL stream_occupancy: got %0d expected <=1", bus.occupancy); end
        end
        drive(1'b0, '0);
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            n_bad++; $display("FAIL stream_end: got v=%b occ=%0d expected v=0 occ=0", bus.out_valid, bus.occupancy); end
        $display("test_stream done");
    endtask

    task automatic test_skid();
        entry_t e;
        drain();
        bus.out_ready = 1'b0;
        e = rand_entry(); e.alu = 16'h1234; drive(1'b1, e); tick();
        e.alu = 16'hBEEF; drive(1'b1, e); tick();
        n_cmp++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL skid_full: got occ=%0d rdy=%b expected occ=2 rdy=0", bus.occupancy, bus.in_ready); end
        e.alu = 16'hCAFE; drive(1'b1, e); tick();
        n_cmp++; if (bus.occupancy !== 2'd2 || bus.AluResOut !== 16'h1234) begin
            n_bad++; $display("FAIL skid_hold: got occ=%0d %h expected occ=2 1234", bus.occupancy, bus.AluResOut); end
        bus.out_ready = 1'b1; tick();
        n_cmp++; if (bus.AluResOut !== 16'hBEEF || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL skid_second: got %h occ=%0d rdy=%b expected BEEF occ=1 rdy=1", bus.AluResOut, bus.occupancy, bus.in_ready); end
        tick();
        n_cmp++; if (bus.AluResOut !== 16'hCAFE || bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL skid_third: got %h v=%b expected CAFE v=1", bus.AluResOut, bus.out_valid); end
        drive(1'b0, '0); tick();
        n_cmp++; if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL skid_drain: got occ=%0d expected 0", bus.occupancy); end
        $display("test_skid done");
    endtask

    task automatic test_stall_cnt();
        drain();
        bus.out_ready = 1'b0; bus.clr_stat = 1'b1;
        drive(1'b1, rand_entry()); tick();
        bus.clr_stat = 1'b0; drive(1'b0, '0);
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL stall_clear0: got %h expected 0", bus.stall_cnt); end
        repeat (7) tick();
        n_cmp++; if (bus.stall_cnt !== 16'd7) begin n_bad++; $display("FAIL stall_seven: got %h expected 7", bus.stall_cnt); end
        bus.clr_stat = 1'b1; tick(); bus.clr_stat = 1'b0;
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL stall_clr_with_stall: got %h expected 0", bus.stall_cnt); end
        bus4.in_valid = 1'b1; tick(); bus4.in_valid = 1'b0;
        repeat (10) tick();
        n_cmp++; if (bus4.stall_cnt !== 4'hA) begin n_bad++; $display("FAIL stall4_ten: got %h expected a", bus4.stall_cnt); end
        repeat (10) tick();
        n_cmp++; if (bus4.stall_cnt !== 4'hF) begin n_bad++; $display("FAIL stall4_saturate: got %h expected f", bus4.stall_cnt); end
        $display("test_stall_cnt done");
    endtask

    task automatic test_flush();
        entry_t e;
        drain();
        bus.out_ready = 1'b0;
        e = rand_entry(); e.rw = 1'b1; e.de = 1'b1;
        drive(1'b1, e); tick();
        e.alu = e.alu + 16'd1; drive(1'b1, e); tick();
        n_cmp++; if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_prefull: got occ=%0d expected 2", bus.occupancy); end
        e.alu = 16'h5555; drive(1'b1, e); bus.flush = 1'b1; tick();
        bus.flush = 1'b0; drive(1'b0, '0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            n_bad++; $display("FAIL flush_empty: got v=%b occ=%0d expected v=0 occ=0", bus.out_valid, bus.occupancy); end
        n_cmp++; if (bus.RegWriteOut !== 1'b0 || bus.DMemEnOut !== 1'b0) begin
            n_bad++; $display("FAIL flush_gating: got rw=%b de=%b expected 0 0", bus.RegWriteOut, bus.DMemEnOut); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.AluResOut === 16'h5555) begin
                n_bad++; $display("FAIL flush_discard: got v=%b %h expected v=0 not 5555", bus.out_valid, bus.AluResOut); end
        end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        entry_t e;
        drain();
        bus.out_ready = 1'b0;
        drive(1'b1, rand_entry()); tick();
        drive(1'b1, rand_entry()); tick();
        #2 rst = 1'b0;
        q.delete(); last_main = '0; m_stall = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin
            n_bad++; $display("FAIL async_reset: got v=%b occ=%0d expected v=0 occ=0", bus.out_valid, bus.occupancy); end
        @(negedge clk);
        drive(1'b0, '0);
        tick();
        rst = 1'b1;
        e = rand_entry();
        drive(1'b1, e); tick(); drive(1'b0, '0);
        n_cmp++; if (bus.out_valid !== 1'b1 || dut_out() !== e) begin
            n_bad++; $display("FAIL async_reset_recover: got v=%b %h expected v=1 %h", bus.out_valid, dut_out(), e); end
        $display("test_async_reset done");
    endtask

    task automatic test_passthrough();
        entry_t e;
        drain();
        e = rand_entry(); e.dump = 1'b1; e.rd = 3'b101;
        drive(1'b1, e); tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || dut_out() !== e) begin
            n_bad++; $display("FAIL pass_entry: got v=%b %h expected v=1 %h", bus.out_valid, dut_out(), e); end
        drive(1'b0, '0); tick();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.DMemDumpOut !== 1'b0 || bus.RdAddrOut !== 3'b101) begin
            n_bad++; $display("FAIL pass_bubble: got v=%b dump=%b rd=%b expected v=0 dump=0 rd=101", bus.out_valid, bus.DMemDumpOut, bus.RdAddrOut); end
        $display("test_passthrough done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            n_cmp++; if (bus.out_valid !== (q.size() > 0)) begin
                n_bad++; $display("FAIL rand_out_valid cyc %0d: got %b expected %b", i, bus.out_valid, q.size() > 0); end
            n_cmp++; if (bus.in_ready !== (q.size() < 2)) begin
                n_bad++; $display("FAIL rand_in_ready cyc %0d: got %b expected %b", i, bus.in_ready, q.size() < 2); end
            n_cmp++; if (bus.occupancy !== 2'(q.size())) begin
                n_bad++; $display("FAIL rand_occupancy cyc %0d: got %0d expected %0d", i, bus.occupancy, q.size()); end
            n_cmp++; if (bus.stall_cnt !== 16'(m_stall)) begin
                n_bad++; $display("FAIL rand_stall_cnt cyc %0d: got %0d expected %0d", i, bus.stall_cnt, m_stall); end
            n_cmp++; if (dut_out() !== exp_out()) begin
                n_bad++; $display("FAIL rand_payload cyc %0d: got %h expected %h", i, dut_out(), exp_out()); end
            drive(($urandom_range(0, 9) < 7), rand_entry());
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 31) == 0);
            bus.clr_stat  = ($urandom_range(0, 31) == 0);
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        bus.flush = 1'b0; bus.clr_stat = 1'b0; bus.out_ready = 1'b0;
        drive(1'b0, '0);
        bus4.flush = 1'b0; bus4.clr_stat = 1'b0; bus4.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.AluResIn = '0; bus4.RtIn = '0;
        bus4.RegWriteIn = 1'b0; bus4.DMemWriteIn = 1'b0; bus4.DMemEnIn = 1'b0;
        bus4.MemToRegIn = 1'b0; bus4.DMemDumpIn = 1'b0; bus4.RdAddrIn = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_skid();
        test_stall_cnt();
        test_flush();
        test_async_reset();
        test_passthrough();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
